// File: rtl/demux_pkg.sv
// Shared definitions for the 1:4 stream demultiplexer.
// Optional feature macro: DEMUX_STATS_EN (per-channel delivery counters).
package demux_pkg;

  localparam int unsigned NCH   = 4;
  localparam int unsigned SEL_W = 2;

  localparam logic [SEL_W-1:0] CH_A = 2'd0;
  localparam logic [SEL_W-1:0] CH_B = 2'd1;
  localparam logic [SEL_W-1:0] CH_C = 2'd2;
  localparam logic [SEL_W-1:0] CH_D = 2'd3;

  typedef enum logic {
    SLOT_EMPTY,
    SLOT_FULL
  } slot_state_t;

  // One-hot decode of a channel select.
  function automatic logic [NCH-1:0] sel_decode(input logic [SEL_W-1:0] sel);
    logic [NCH-1:0] oh;
    oh = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/demux_out_slot.sv
// One-entry output register for a single demux channel.
// A load takes priority over a drain, so a simultaneous drain and load keeps the slot full
// and replaces the held word.
module demux_out_slot
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             drain,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  slot_state_t      state_q, state_d;
  logic [WIDTH-1:0] data_q;

  // Next-state for the EMPTY/FULL slot FSM.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SLOT_EMPTY: if (load) state_d = SLOT_FULL;
      SLOT_FULL: begin
        if (load)       state_d = SLOT_FULL;
        else if (drain) state_d = SLOT_EMPTY;
      end
      default: state_d = SLOT_EMPTY;
    endcase
  end

  // Slot state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= SLOT_EMPTY;
    else        state_q <= state_d;
  end

  // Data register; holds its last value while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    data_q <= '0;
    else if (load) data_q <= data_in;
  end

  assign valid = (state_q == SLOT_FULL);
  assign data  = data_q;

endmodule

// File: rtl/onetofour_demux_stream.sv
// Registered 1:4 stream demultiplexer with per-channel back-pressure.
// Define DEMUX_STATS_EN to add saturating per-channel delivered-word counters (dlv_cnt).
module onetofour_demux_stream
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic [WIDTH-1:0]       in_data,
  output logic [NCH-1:0]         out_valid,
  input  logic [NCH-1:0]         out_ready,
  output logic [NCH*WIDTH-1:0]   out_data
`ifdef DEMUX_STATS_EN
  ,
  output logic [NCH*CNT_W-1:0]   dlv_cnt
`endif
);

  if (CNT_W == 0) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end

  logic           accept;
  logic [NCH-1:0] load;

  // Ready depends only on the addressed slot and its consumer, never on in_valid.
  always_comb begin
    in_ready = !out_valid[in_sel] || out_ready[in_sel];
    accept   = in_valid && in_ready;
    load     = sel_decode(in_sel) & {NCH{accept}};
  end

  for (genvar k = 0; k < NCH; k++) begin : g_slot
    demux_out_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load[k]),
      .data_in (in_data),
      .drain   (out_ready[k]),
      .valid   (out_valid[k]),
      .data    (out_data[k*WIDTH +: WIDTH])
    );
  end

`ifdef DEMUX_STATS_EN
  for (genvar k = 0; k < NCH; k++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q;

    // Count completed output handshakes, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else if (out_valid[k] && out_ready[k] && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign dlv_cnt[k*CNT_W +: CNT_W] = cnt_q;
  end
`endif

endmodule

// File: tb/tb_onetofour_demux_stream.sv
// Self-checking bench for onetofour_demux_stream.
// Honours DEMUX_STATS_EN: with it defined the DUT is built with CNT_W=4 and counters are checked.
module tb_onetofour_demux_stream;

  localparam int unsigned W = 8;
`ifdef DEMUX_STATS_EN
  localparam int unsigned CW = 4;
`else
  localparam int unsigned CW = 16;
`endif
  localparam int unsigned CMAX = (1 << CW) - 1;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_sel;
  logic [W-1:0]  in_data;
  logic [3:0]    out_valid;
  logic [3:0]    out_ready;
  logic [4*W-1:0] out_data;
`ifdef DEMUX_STATS_EN
  logic [4*CW-1:0] dlv_cnt;
`endif

  onetofour_demux_stream #(
    .WIDTH (W),
    .CNT_W (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef DEMUX_STATS_EN
    ,
    .dlv_cnt   (dlv_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: per-channel queue of words accepted but not yet consumed,
  // last word ever written per channel, and count of words consumed per channel.
  logic [W-1:0] q [4][$];
  logic [W-1:0] last_w [4];
  int unsigned  dcnt [4];

  task automatic model_clear();
    for (int k = 0; k < 4; k++) begin
      q[k].delete();
      last_w[k] = '0;
      dcnt[k]   = 0;
    end
  endtask

  // Apply one clock edge to the model using the inputs present before the edge.
  task automatic model_update();
    bit acc;
    if (rst_n) begin
      acc = in_valid && ((q[in_sel].size() == 0) || out_ready[in_sel]);
      for (int k = 0; k < 4; k++) begin
        if (q[k].size() != 0 && out_ready[k]) begin
          void'(q[k].pop_front());
          if (dcnt[k] < CMAX) dcnt[k]++;
        end
      end
      if (acc) begin
        q[in_sel].push_back(in_data);
        last_w[in_sel] = in_data;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic lit(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    logic [3:0]     ev;
    logic [4*W-1:0] ed;
    logic           er;
    for (int k = 0; k < 4; k++) begin
      ev[k] = (q[k].size() != 0);
      ed[k*W +: W] = (q[k].size() != 0) ? q[k][0] : last_w[k];
    end
    er = (q[in_sel].size() == 0) || out_ready[in_sel];
    lit("cyc_out_valid", 64'(out_valid), 64'(ev));
    lit("cyc_out_data", 64'(out_data), 64'(ed));
    lit("cyc_in_ready", 64'(in_ready), 64'(er));
`ifdef DEMUX_STATS_EN
    for (int k = 0; k < 4; k++) begin
      lit("cyc_dlv_cnt", 64'(dlv_cnt[k*CW +: CW]), 64'(dcnt[k]));
    end
`endif
  end

  task automatic send(input logic [1:0] sel, input logic [W-1:0] d);
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = d;
    step();
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_sel    = 2'd0;
    in_data   = 8'h5A;
    out_ready = 4'b0000;
    model_clear();

    // Reset held with in_valid asserted: nothing accepted.
    step();
    step();
    lit("rst_out_valid", 64'(out_valid), 64'h0);
    lit("rst_out_data", 64'(out_data), 64'h0);
    step();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    #1;
    lit("rst_in_ready", 64'(in_ready), 64'h1);

    // Routing.
    out_ready = 4'b1111;
    send(2'd0, 8'hA1);
    lit("route_a_valid", 64'(out_valid), 64'b0001);
    lit("route_a_data", 64'(out_data[7:0]), 64'hA1);
    send(2'd1, 8'hB2);
    lit("route_b_valid", 64'(out_valid), 64'b0010);
    lit("route_b_data", 64'(out_data[15:8]), 64'hB2);
    send(2'd2, 8'hC3);
    lit("route_c_valid", 64'(out_valid), 64'b0100);
    lit("route_c_data", 64'(out_data[23:16]), 64'hC3);
    send(2'd3, 8'hD4);
    lit("route_d_valid", 64'(out_valid), 64'b1000);
    lit("route_d_data", 64'(out_data[31:24]), 64'hD4);
    in_valid = 1'b0;
    step();

    // Back-pressure on channel B.
    out_ready = 4'b1101;
    send(2'd1, 8'h11);
    lit("bp_b_valid", 64'(out_valid[1]), 64'h1);
    in_data = 8'h22;
    #1;
    lit("bp_stall_ready", 64'(in_ready), 64'h0);
    step();
    step();
    lit("bp_hold_data", 64'(out_data[15:8]), 64'h11);
    lit("bp_hold_valid", 64'(out_valid[1]), 64'h1);
    out_ready = 4'b1111;
    #1;
    lit("bp_release_ready", 64'(in_ready), 64'h1);
    step();
    lit("bp_second_data", 64'(out_data[15:8]), 64'h22);
    in_valid = 1'b0;
    step();
    lit("bp_drained", 64'(out_valid), 64'h0);

    // Simultaneous drain and load on channel C.
    out_ready = 4'b1011;
    send(2'd2, 8'h55);
    lit("dl_c_first", 64'(out_data[23:16]), 64'h55);
    out_ready = 4'b1111;
    send(2'd2, 8'h66);
    lit("dl_c_valid", 64'(out_valid[2]), 64'h1);
    lit("dl_c_data", 64'(out_data[23:16]), 64'h66);
    in_valid = 1'b0;
    step();
    lit("dl_c_empty", 64'(out_valid), 64'h0);

    // Mid-operation asynchronous reset.
    out_ready = 4'b0000;
    send(2'd0, 8'h01);
    send(2'd1, 8'h02);
    send(2'd2, 8'h03);
    send(2'd3, 8'h04);
    in_valid = 1'b0;
    lit("mid_all_full", 64'(out_valid), 64'hF);
    rst_n = 1'b0;
    model_clear();
    #1;
    lit("mid_async_valid", 64'(out_valid), 64'h0);
    lit("mid_async_data", 64'(out_data), 64'h0);
    #2;
    rst_n = 1'b1;
    step();
    lit("mid_no_stale", 64'(out_valid), 64'h0);
    out_ready = 4'b1111;
    step();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_sel    = 2'($urandom_range(0, 3));
      in_data   = 8'($urandom);
      out_ready = 4'($urandom);
      step();
    end
    in_valid = 1'b0;

`ifdef DEMUX_STATS_EN
    // Counter saturation on channel D.
    rst_n = 1'b0;
    model_clear();
    step();
    rst_n     = 1'b1;
    out_ready = 4'b1111;
    for (int i = 0; i < 20; i++) send(2'd3, 8'(i));
    in_valid = 1'b0;
    step();
    lit("sat_cnt_d", 64'(dlv_cnt[15:12]), 64'hF);
    lit("sat_cnt_others", 64'(dlv_cnt[11:0]), 64'h0);
`endif

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
